// File: rtl/bitbrick_seq.sv
// Sequences 2-bit chunk pairs through an external bitbrick and shift-accumulates.
// Optional BBSEQ_SKIP_ZERO_EN skips all-zero A rows.
module bitbrick_seq #(
  parameter int MAX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_BITS-1:0]   a,
  input  logic [MAX_BITS-1:0]   b,
  input  logic                  sa,
  input  logic                  sb,
  input  logic [1:0]            prec_a,
  input  logic [1:0]            prec_b,
  output logic [1:0]            bb_a,
  output logic [1:0]            bb_b,
  output logic                  bb_sa,
  output logic                  bb_sb,
  input  logic [3:0]            bb_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MAX_BITS-1:0] product
);

  localparam int NCH = MAX_BITS / 2;
  localparam int NW  = $clog2(NCH + 1);
  localparam int PW  = 2 * MAX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] a_q, a_d;
  logic [MAX_BITS-1:0] b_q, b_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [NW-1:0]       na_q, na_d;
  logic [NW-1:0]       nb_q, nb_d;
  logic [NW-1:0]       i_q, i_d;
  logic [NW-1:0]       j_q, j_d;
  logic [PW-1:0]       acc_q, acc_d;

  logic                last_i, last_j;
  logic [NW+1:0]       sh;
  logic [PW-1:0]       ext_p;

  // chunk count = width/2, clamped to the chunks available
  function automatic logic [NW-1:0] chunks(input logic [1:0] p);
    int c;
    c = 1 << p;
    if (c > NCH) c = NCH;
    return NW'(c);
  endfunction

`ifdef BBSEQ_SKIP_ZERO_EN
  logic [NW:0] nz;

  // lowest nonzero chunk index >= start and < n; MSB flags found
  function automatic logic [NW:0] next_nz(
    input logic [MAX_BITS-1:0] v,
    input logic [NW:0]         start,
    input logic [NW-1:0]       n
  );
    logic [NW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if ((NW+1)'(k) >= start && NW'(k) < n &&
          v[2*k +: 2] != 2'b00)
        r = {1'b1, NW'(k)};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      na_q    <= '0;
      nb_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    na_d      = na_q;
    nb_d      = nb_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    bb_a      = 2'b00;
    bb_b      = 2'b00;
    bb_sa     = 1'b0;
    bb_sb     = 1'b0;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    product   = (state_q == S_DONE) ? acc_q : '0;
    last_i    = (i_q == na_q - NW'(1));
    last_j    = (j_q == nb_q - NW'(1));
    sh        = (NW+2)'({1'b0, i_q} + {1'b0, j_q}) << 1;
    ext_p     = '0;
`ifdef BBSEQ_SKIP_ZERO_EN
    nz        = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sa_d    = sa;
          sb_d    = sb;
          na_d    = chunks(prec_a);
          nb_d    = chunks(prec_b);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
`ifdef BBSEQ_SKIP_ZERO_EN
          nz = next_nz(a, '0, na_d);
          if (nz[NW]) i_d = nz[NW-1:0];
          else        state_d = S_DONE;
`endif
        end
      end
      S_RUN: begin
        bb_a  = a_q[2*i_q +: 2];
        bb_b  = b_q[2*j_q +: 2];
        bb_sa = sa_q && last_i;
        bb_sb = sb_q && last_j;
        // signed chunk products must sign-extend; 3*3=9 stays positive
        ext_p = (bb_sa || bb_sb) ? PW'($signed(bb_p)) : PW'(bb_p);
        acc_d = acc_q + (ext_p << sh);
        if (!last_j) begin
          j_d = j_q + NW'(1);
        end else begin
          j_d = '0;
`ifdef BBSEQ_SKIP_ZERO_EN
          nz = next_nz(a_q, {1'b0, i_q} + (NW+1)'(1), na_q);
          if (nz[NW]) i_d = nz[NW-1:0];
          else        state_d = S_DONE;
`else
          if (last_i) state_d = S_DONE;
          else        i_d = i_q + NW'(1);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitbrick_seq.sv
// Directed bench for bitbrick_seq with a behavioural bitbrick and product scoreboard.
// Expected products come from a direct integer model of the truncated operands.
module tb_bitbrick_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        sa, sb;
  logic [1:0]  prec_a, prec_b;
  logic [1:0]  bb_a, bb_b;
  logic        bb_sa, bb_sb;
  logic [3:0]  bb_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bitbrick_seq #(.MAX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sa(sa), .sb(sb),
    .prec_a(prec_a), .prec_b(prec_b),
    .bb_a(bb_a), .bb_b(bb_b),
    .bb_sa(bb_sa), .bb_sb(bb_sb), .bb_p(bb_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  // behavioural 2x2 bitbrick
  always_comb begin
    int x, y;
    x = bb_sa ? int'($signed(bb_a)) : int'(bb_a);
    y = bb_sb ? int'($signed(bb_b)) : int'(bb_b);
    bb_p = 4'(x * y);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int width_of(input logic [1:0] p);
    int w;
    w = 2 << p;
    return (w > 8) ? 8 : w;
  endfunction

  function automatic logic [15:0] model(
    input logic [7:0] x, input logic [7:0] y,
    input logic xs, input logic ys,
    input logic [1:0] px, input logic [1:0] py);
    int wx, wy, vx, vy;
    wx = width_of(px);
    wy = width_of(py);
    vx = int'(x) & ((1 << wx) - 1);
    vy = int'(y) & ((1 << wy) - 1);
    if (xs && vx[wx-1]) vx -= (1 << wx);
    if (ys && vy[wy-1]) vy -= (1 << wy);
    return 16'(vx * vy);
  endfunction

  function automatic int latency(
    input logic [7:0] x, input logic [1:0] px, input logic [1:0] py);
    int na, nb, rows;
    na = width_of(px) / 2;
    nb = width_of(py) / 2;
    rows = na;
`ifdef BBSEQ_SKIP_ZERO_EN
    rows = 0;
    for (int k = 0; k < na; k++)
      if (((int'(x) >> (2 * k)) & 3) != 0) rows++;
`endif
    return rows * nb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!in_ready && c < 50) begin
      step();
      c++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // offer an op, accept it on the next edge; returns after the accept edge
  task automatic offer(input logic [7:0] xa, input logic [7:0] xb,
                       input logic xsa, input logic xsb,
                       input logic [1:0] pa, input logic [1:0] pb);
    wait_ready();
    a = xa; b = xb; sa = xsa; sb = xsb;
    prec_a = pa; prec_b = pb;
    in_valid = 1'b1;
    exp_q.push_back(model(xa, xb, xsa, xsb, pa, pb));
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int c;
    logic [15:0] e;
    c = 0;
    while (!out_valid && c < 100) begin
      step();
      c++;
    end
    check({tag, "_lat"}, 32'(c), 32'(exp_lat));
    e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_prod"}, 32'(product), 32'(e));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic full_op(input string tag,
                         input logic [7:0] xa, input logic [7:0] xb,
                         input logic xsa, input logic xsb,
                         input logic [1:0] pa, input logic [1:0] pb);
    int lat, nb;
    lat = latency(xa, pa, pb);
    nb = width_of(pb) / 2;
    offer(xa, xb, xsa, xsb, pa, pb);
    if (lat > 0) begin
      check({tag, "_bb_b0"}, 32'(bb_b), 32'(xb[1:0]));
      check({tag, "_bb_sb0"}, 32'(bb_sb), 32'(xsb && nb == 1));
    end
    collect(tag, lat);
    release_out(tag);
  endtask

  initial begin
    logic [15:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sa = 1'b0; sb = 1'b0;
    prec_a = '0; prec_b = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_bb", 32'({bb_a, bb_b, bb_sa, bb_sb}), 32'd0);
    rst_n = 1'b1;
    step();

    full_op("u3x3", 8'h03, 8'h03, 1'b0, 1'b0, 2'd0, 2'd0);
    full_op("s80x7f", 8'h80, 8'h7F, 1'b1, 1'b0, 2'd3, 2'd3);
    full_op("mixed", 8'hAF, 8'hFF, 1'b1, 1'b0, 2'd1, 2'd2);
    full_op("ss_neg", 8'h80, 8'h80, 1'b1, 1'b1, 2'd2, 2'd2);
    full_op("skip30", 8'h30, 8'h05, 1'b0, 1'b0, 2'd3, 2'd3);
    full_op("zero_a", 8'h00, 8'h5A, 1'b0, 1'b0, 2'd3, 2'd3);
    full_op("zero_s", 8'h0C, 8'hF3, 1'b1, 1'b1, 2'd3, 2'd1);

    for (int k = 0; k < 8; k++) begin
      full_op("rand", 8'($urandom), 8'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), 2'($urandom));
    end

    // backpressure with an ignored offer while busy
    offer(8'h12, 8'h34, 1'b0, 1'b1, 2'd3, 2'd3);
    collect("bp", latency(8'h12, 2'd3, 2'd3));
    held = product;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ov_hold", 32'(out_valid), 32'd1);
      check("bp_prod_hold", 32'(product), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    step();
    check("bp_no_ghost", 32'(out_valid | (exp_q.size() != 0)), 32'd0);

    // reset during the third RUN cycle of an 8x8 op
    offer(8'h5B, 8'hC7, 1'b1, 1'b1, 2'd3, 2'd3);
    void'(exp_q.pop_back());
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_bb", 32'({bb_a, bb_b, bb_sa, bb_sb}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_rdy", 32'(in_ready), 32'd1);
    full_op("post_rst", 8'h02, 8'h03, 1'b0, 1'b0, 2'd0, 2'd0);
    check("post_rst_val", 32'(model(8'h02, 8'h03, 1'b0, 1'b0, 2'd0, 2'd0)),
          32'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitbrick_seq.md
Name: bitbrick_seq

Overview:
Multi-cycle precision-fusion controller that drives one external bitbrick (2-bit signed/unsigned multiplier).
- Accepts an operand pair with per-operand precision and sign flags.
- Walks all 2-bit chunk pairs through the bitbrick, one pair per cycle, and shift-accumulates the 4-bit partial products.
- Returns a full-width, sign-correct product with a valid/ready handshake.
- Sits between the PE operand buffers and the bitbrick instance.

Parameters:
MAX_BITS, 8, maximum operand width; power of two, 2..16.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
in_valid  in  1  operand pair offered.
in_ready  out  1  high only in IDLE.
a  in  MAX_BITS  operand A; bits above the selected precision are ignored.
b  in  MAX_BITS  operand B; same rule as A.
sa  in  1  A is signed.
sb  in  1  B is signed.
prec_a  in  2  A width = 2<<prec_a bits, clamped to MAX_BITS.
prec_b  in  2  B width = 2<<prec_b bits, clamped to MAX_BITS.
bb_a  out  2  chunk of A to the bitbrick.
bb_b  out  2  chunk of B to the bitbrick.
bb_sa  out  1  A chunk is signed.
bb_sb  out  1  B chunk is signed.
bb_p  in  4  bitbrick product (combinational from bb_*).
out_valid  out  1  product available.
out_ready  in  1  consumer accepts the product.
product  out  2*MAX_BITS  result, sign- or zero-extended.

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid=0; product=0; bb_a=bb_b=bb_sa=bb_sb=0; accumulator and chunk counters 0. Reset may assert in any state; the operation in flight is discarded, with no partial output.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_valid && in_ready latches a, b, sa, sb and the clamped chunk counts na=wa/2 and nb=wb/2. It clears the accumulator, sets i=j=0 and moves to RUN.
  - RUN: drive bb_a=A[2i+1:2i] and bb_b=B[2j+1:2j].
    - bb_sa = sa && (i==na-1). bb_sb = sb && (j==nb-1). Only top chunks are signed.
    - Each cycle add ext(bb_p) << 2(i+j) to the 2*MAX_BITS accumulator, modulo 2^(2*MAX_BITS).
    - ext(bb_p) sign-extends if bb_sa|bb_sb, otherwise zero-extends. Unsigned 3*3=9 must not be read as -7.
    - j increments; on j==nb-1, j wraps to 0 and i increments. The pair i==na-1, j==nb-1 is the last; state moves to DONE.
  - DONE: product=accumulator and out_valid=1. On out_ready, out_valid drops next cycle and state moves to IDLE.
- bb_* outputs are 0 outside RUN.
- Latency: accept at edge T gives out_valid at edge T+na*nb, i.e. na*nb RUN cycles.
- Throughput: one result per na*nb+2 cycles. There is no overlap; in_ready stays low in RUN and DONE.
- product and out_valid hold stable while out_ready is low. in_valid while busy is ignored; the bench must not treat it as accepted.
- prec codes beyond MAX_BITS clamp (e.g. MAX_BITS=8, prec=3 means 8 bits).
- The result equals the exact product of the truncated operands, each sign-extended if signed; it always fits in 2*MAX_BITS.

Optional Feature:
BBSEQ_SKIP_ZERO_EN
- Defined: at accept and after finishing each row i, the i counter jumps to the next A chunk that is nonzero. All-zero rows are never issued; they contribute exactly zero, whether signed or unsigned.
  - If no nonzero chunk remains, go directly to DONE.
  - A==0 gives out_valid one cycle after accept, product 0.
  - Latency = nnz_a*nb.
- Undefined: every row is issued; latency is always na*nb. Results are identical in both builds.

Test Plan:
- prec_a=prec_b=0, a=3, b=3, sa=sb=0 -> 1 RUN cycle; product=16'h0009; out_valid at accept edge +1.
- 8x8, a=8'h80, b=8'h7F, sa=1, sb=0 -> 16 RUN cycles; product=16'hC080 (-16256).
- prec_a=1, a=8'hAF (upper nibble ignored), sa=1; prec_b=2, b=8'hFF, sb=0 -> 8 cycles; product=16'hFF01 (-255).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- rst_n low on the 3rd RUN cycle of an 8x8 op -> immediately out_valid=0 and bb_*=0. After release, in_ready=1, and the next op 2*3 (prec 0) gives 16'h0006.
- BBSEQ_SKIP_ZERO_EN, 8x8 unsigned:
  - a=8'h30, b=8'h05 -> 4 RUN cycles; product=16'h00F0.
  - a=0 -> out_valid one cycle after accept; product=0.
  - Without the macro, the a=8'h30 case takes 16 cycles and gives the same product.
